lucaz97_tt_top: RTL and testbench
=================================

Name: lucaz97_tt_top

Overview:
TinyTapeout-style top wrapping a logic-locked 8-bit accumulator CPU (QTCore-A1 class) with a single 160-bit scan chain. The scan chain holds all processor state, memory, the IO register and a 16-bit unlock key. The processor executes correctly only when the key register holds KEY. The host loads and unloads programs and state exclusively through the scan chain.

Parameters:
KEY, 16'hBFF9, unlock value for chain bits 159:144.
MEM_BYTES, 14, RAM bytes at addresses 0–13.

Ports:
io_in[0]  in  1  clk; all state updates on the rising edge.
io_in[1]  in  1  rst; asynchronous, active-high.
io_in[2]  in  1  scan_enable_n; active-low.
io_in[3]  in  1  proc_en_n; active-low.
io_in[4]  in  1  scan_in.
io_in[5]  in  1  btn_in.
io_in[7:6]  in  2  unused.
io_out[6:0]  out  7  LEDs = IO[7:1].
io_out[7]  out  1  scan_en ? chain[159] : (state==HALT).
Interface decision: one clock; reset is asynchronous and active-high. The codebase names these io_in[0] (clk) and io_in[1] (rst).

Behaviour:
- Chain bit map: 2:0 state; 7:3 PC; 15:8 IR; 23:16 ACC; 24+8n+7:24+8n MEM[n] for n=0..13; 143:136 IO; 159:144 key.
- Scan shift (scan_en=1):
  - Every clock, chain[0]←scan_in and chain[i]←chain[i-1].
  - Scan overrides processor execution.
  - 160 clocks give a full exchange. Output order is identical to input order.
- Neither scan_en nor proc_en asserted: all registers hold.
- Reset values: state=FETCH, PC=0, IR=0, ACC=0, MEM=0, IO=0, key=0 (locked). Outputs at reset: LEDs=0, io_out[7]=0.
- State register is one-hot: 001 FETCH, 010 EXEC, 100 HALT. Other codes go to FETCH on the next enabled clock.
- FETCH: IR←mem[PC]; PC←PC+1 (5-bit wrap); next state EXEC.
- EXEC: execute IR; next state FETCH, or HALT for HLT.
- HALT: hold until reset or scan.
- Each instruction takes 2 clocks.
- Address space (5-bit addr = IR[4:0]):
  - 0–13: RAM.
  - 14: IO register. Reads return {IO[7:1], btn_in}; writes load all 8 bits.
  - 15–31: read 0x00; writes ignored.
- Memory-op instructions, IR[7:5] selects:
  - 000 LDA: ACC←M.
  - 001 STA: M←ACC.
  - 010 ADD, 011 SUB: 8-bit wrap.
  - 100 AND, 101 OR, 110 XOR.
- 1110_IIII ADDI: ACC←ACC+sign_extend(IIII).
- 1111_xxxx single-byte ops. Branch offsets are relative to the branch's own address B.
  - F0 JMP: PC←ACC[4:0].
  - F1 JSR: ACC←B+1; PC←ACC[4:0].
  - F2 BEQ_FWD: if ACC==0, PC←B+2.
  - F3 BEQ_BWD: if ACC==0, PC←B-2.
  - F4 BNE_FWD: if ACC!=0, PC←B+2.
  - F5 BNE_BWD: if ACC!=0, PC←B-2.
  - F6 SHL, F7 SHR: zero fill.
  - F8 SETNE: ACC←(ACC!=0).
  - F9 ROL, FA ROR.
  - FB LDAR: ACC←M[ACC[4:0]].
  - FC DEC: ACC←ACC-1.
  - FD CLR: ACC←0.
  - FE NOT: ACC←~ACC.
  - FF HLT.
- Lock: locked = (key != KEY). While locked, every ACC write stores the bitwise inverse of the computed value. Memory, PC and IR behave normally.
- Reset asserted mid-run or mid-scan clears immediately, independent of clk.

Decomposition:
- Shared package qtcore_pkg holds:
  - opcode constants;
  - state encodings;
  - address map constants (IO_ADDR=14);
  - KEY default;
  - chain bit offsets.
- One natural sub-module: qt_scan_reg, a parameterised-width register with async reset, parallel load enable, and scan shift (scan_in/scan_out).
- All chain elements are qt_scan_reg instances, daisy-chained.

Test Plan:
1. Reset, then scan in: state=001, PC=1, IR=E0, ACC=01, MEM[0..4]=E0..E4, IO=F0, key=BFF9.
   -> LEDs=1111000; internal registers match the loaded values.
2. From case 1, proc_en for 8 clocks, then full unload.
   -> ACC=0x0B, PC=5, IR=E4, state=001, MEM[0..4] unchanged.
3. Reset, then scan in:
   - MEM[0..13] = 0D F2 FC 2D F5 EF F8 EF E1 2C F3 FF 00 10;
   - IO=00, key=BFF9, PC=0, state=FETCH.
   Run ≤256 clocks.
   -> io_out[7]=1 (halted); on unload MEM[13]=00, MEM[12]=01.
4. Case 2 with key=0000.
   -> ACC=0xFF after 8 clocks (locked inversion).
5. Assert rst mid-run of case 3, asynchronously between clock edges.
   -> Immediately PC=0, state=FETCH, ACC=0, key=0, io_out[7]=0.
6. Assert scan_en and proc_en together.
   -> Chain shifts only; no instruction executes.

Source files
------------

// File: rtl/qtcore_pkg.sv
// qtcore_pkg: shared constants for the logic-locked QTCore-A1 style CPU.
//   - FSM state encoding (one-hot, 3 bits)
//   - opcode constants (memory-op group selectors and single-byte ops)
//   - address map and default unlock key
//   - scan chain bit offsets (bit 0 is the first flop after scan_in)
package qtcore_pkg;

  localparam logic [15:0] KEY_DEFAULT = 16'hBFF9;
  localparam int          MEM_BYTES   = 14;
  localparam logic [4:0]  IO_ADDR     = 5'd14;

  // Scan chain layout, low bit of each field.
  localparam int CHAIN_W   = 160;
  localparam int OFS_STATE = 0;
  localparam int OFS_PC    = 3;
  localparam int OFS_IR    = 8;
  localparam int OFS_ACC   = 16;
  localparam int OFS_MEM   = 24;
  localparam int OFS_IO    = 136;
  localparam int OFS_KEY   = 144;

  typedef enum logic [2:0] {
    ST_FETCH = 3'b001,
    ST_EXEC  = 3'b010,
    ST_HALT  = 3'b100
  } state_e;

  // IR[7:5] for memory-operand instructions; 111 is the immediate/single-byte group.
  localparam logic [2:0] OPC_LDA = 3'b000;
  localparam logic [2:0] OPC_STA = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;
  localparam logic [2:0] OPC_AND = 3'b100;
  localparam logic [2:0] OPC_OR  = 3'b101;
  localparam logic [2:0] OPC_XOR = 3'b110;
  localparam logic [2:0] OPC_EXT = 3'b111;

  localparam logic [7:0] OP_JMP     = 8'hF0;
  localparam logic [7:0] OP_JSR     = 8'hF1;
  localparam logic [7:0] OP_BEQ_FWD = 8'hF2;
  localparam logic [7:0] OP_BEQ_BWD = 8'hF3;
  localparam logic [7:0] OP_BNE_FWD = 8'hF4;
  localparam logic [7:0] OP_BNE_BWD = 8'hF5;
  localparam logic [7:0] OP_SHL     = 8'hF6;
  localparam logic [7:0] OP_SHR     = 8'hF7;
  localparam logic [7:0] OP_SETNE   = 8'hF8;
  localparam logic [7:0] OP_ROL     = 8'hF9;
  localparam logic [7:0] OP_ROR     = 8'hFA;
  localparam logic [7:0] OP_LDAR    = 8'hFB;
  localparam logic [7:0] OP_DEC     = 8'hFC;
  localparam logic [7:0] OP_CLR     = 8'hFD;
  localparam logic [7:0] OP_NOT     = 8'hFE;
  localparam logic [7:0] OP_HLT     = 8'hFF;

  // ADDI immediate is a signed nibble.
  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

endpackage

// File: rtl/qt_scan_reg.sv
// qt_scan_reg: WIDTH-bit register that is either a scan-chain segment or a
// parallel-load register.
//   clk, rst      : rising-edge clock, asynchronous active-high reset to RST_VAL
//   scan_en       : shift q left by one, scan_in entering bit 0 (wins over load)
//   load_en, d    : parallel load when not scanning
//   q, scan_out   : register value; scan_out is the msb feeding the next segment
module qt_scan_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic             scan_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             scan_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (scan_en) begin
      q <= {q[WIDTH-2:0], scan_in};
    end else if (load_en) begin
      q <= d;
    end
  end

  assign scan_out = q[WIDTH-1];

endmodule

// File: rtl/lucaz97_tt_top.sv
// lucaz97_tt_top: TinyTapeout wrapper around a logic-locked 8-bit accumulator
// CPU whose entire state (FSM, PC, IR, ACC, 14-byte RAM, IO register and the
// 16-bit key) sits on one 160-bit scan chain.
//   io_in[0] clk, io_in[1] rst (async, active-high), io_in[2] scan_enable_n,
//   io_in[3] proc_en_n, io_in[4] scan_in, io_in[5] btn_in, io_in[7:6] unused
//   io_out[6:0] LEDs = IO[7:1]
//   io_out[7]   scan_en ? chain msb (scan_out) : halted
// The CPU computes correctly only when the key segment holds KEY; otherwise
// every accumulator write stores the bitwise inverse of the real result.
module lucaz97_tt_top
  import qtcore_pkg::*;
#(
  parameter logic [15:0] KEY = KEY_DEFAULT
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic clk, rst, scan_en, proc_en, scan_in, btn;
  assign clk     = io_in[0];
  assign rst     = io_in[1];
  assign scan_en = ~io_in[2];
  assign proc_en = ~io_in[3];
  assign scan_in = io_in[4];
  assign btn     = io_in[5];

  logic unused_io;
  assign unused_io = &{1'b0, io_in[7:6]};

  // Scan has priority inside qt_scan_reg, so run only needs proc_en.
  logic run;
  assign run = proc_en;

  logic [2:0]  state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  io_q, io_d;
  logic [15:0] key_q;
  logic [7:0]  mem_q [MEM_BYTES];
  logic [7:0]  mem_d [MEM_BYTES];

  // Scan links between chain segments, in chain order.
  logic state_so, pc_so, ir_so, acc_so, io_so, key_so;
  logic [MEM_BYTES:0] mem_link;

  qt_scan_reg #(.WIDTH(OFS_PC - OFS_STATE), .RST_VAL(ST_FETCH)) u_state (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
    .load_en(run), .d(state_d), .q(state_q), .scan_out(state_so)
  );

  qt_scan_reg #(.WIDTH(OFS_IR - OFS_PC)) u_pc (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(state_so),
    .load_en(run), .d(pc_d), .q(pc_q), .scan_out(pc_so)
  );

  qt_scan_reg #(.WIDTH(OFS_ACC - OFS_IR)) u_ir (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(pc_so),
    .load_en(run), .d(ir_d), .q(ir_q), .scan_out(ir_so)
  );

  qt_scan_reg #(.WIDTH(OFS_MEM - OFS_ACC)) u_acc (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(ir_so),
    .load_en(run), .d(acc_d), .q(acc_q), .scan_out(acc_so)
  );

  assign mem_link[0] = acc_so;

  for (genvar n = 0; n < MEM_BYTES; n++) begin : g_mem
    qt_scan_reg #(.WIDTH((OFS_IO - OFS_MEM) / MEM_BYTES)) u_byte (
      .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(mem_link[n]),
      .load_en(run), .d(mem_d[n]), .q(mem_q[n]), .scan_out(mem_link[n+1])
    );
  end

  qt_scan_reg #(.WIDTH(OFS_KEY - OFS_IO)) u_io (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(mem_link[MEM_BYTES]),
    .load_en(run), .d(io_d), .q(io_q), .scan_out(io_so)
  );

  // The key is only ever written by scanning.
  qt_scan_reg #(.WIDTH(CHAIN_W - OFS_KEY)) u_key (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(io_so),
    .load_en(1'b0), .d(key_q), .q(key_q), .scan_out(key_so)
  );

  logic locked;
  assign locked = (key_q != KEY);

  // Single read port: FETCH reads at PC, LDAR at ACC, everything else at IR[4:0].
  logic [4:0] rd_addr;
  logic [7:0] rd_data;

  always_comb begin
    rd_addr = (ir_q == OP_LDAR) ? acc_q[4:0] : ir_q[4:0];
    if (state_q == ST_FETCH) rd_addr = pc_q;
    rd_data = 8'h00;
    if (rd_addr == IO_ADDR) rd_data = {io_q[7:1], btn};
    for (int n = 0; n < MEM_BYTES; n++) begin
      if (rd_addr == 5'(n)) rd_data = mem_q[n];
    end
  end

  // PC already points past the instruction during EXEC, so its own address is PC-1.
  logic [4:0] br_addr;
  assign br_addr = pc_q - 5'd1;

  logic [7:0] acc_res;
  logic       acc_wr;
  logic       st_wr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    io_d    = io_q;
    for (int n = 0; n < MEM_BYTES; n++) mem_d[n] = mem_q[n];
    acc_res = acc_q;
    acc_wr  = 1'b0;
    st_wr   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ir_d    = rd_data;
        pc_d    = pc_q + 5'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (ir_q[7:5] != OPC_EXT) begin
          acc_wr = 1'b1;
          case (ir_q[7:5])
            OPC_LDA: acc_res = rd_data;
            OPC_STA: begin
              acc_wr = 1'b0;
              st_wr  = 1'b1;
            end
            OPC_ADD: acc_res = acc_q + rd_data;
            OPC_SUB: acc_res = acc_q - rd_data;
            OPC_AND: acc_res = acc_q & rd_data;
            OPC_OR:  acc_res = acc_q | rd_data;
            OPC_XOR: acc_res = acc_q ^ rd_data;
            default: acc_wr = 1'b0;
          endcase
        end else if (!ir_q[4]) begin
          acc_wr  = 1'b1;
          acc_res = acc_q + sext4(ir_q[3:0]);
        end else begin
          case (ir_q)
            OP_JMP: pc_d = acc_q[4:0];
            OP_JSR: begin
              // Jump target comes from the old ACC; ACC then holds the return address.
              acc_wr  = 1'b1;
              acc_res = {3'b000, br_addr + 5'd1};
              pc_d    = acc_q[4:0];
            end
            OP_BEQ_FWD: if (acc_q == 8'h00) pc_d = br_addr + 5'd2;
            OP_BEQ_BWD: if (acc_q == 8'h00) pc_d = br_addr - 5'd2;
            OP_BNE_FWD: if (acc_q != 8'h00) pc_d = br_addr + 5'd2;
            OP_BNE_BWD: if (acc_q != 8'h00) pc_d = br_addr - 5'd2;
            OP_SHL:   begin acc_wr = 1'b1; acc_res = {acc_q[6:0], 1'b0}; end
            OP_SHR:   begin acc_wr = 1'b1; acc_res = {1'b0, acc_q[7:1]}; end
            OP_SETNE: begin acc_wr = 1'b1; acc_res = {7'b0, acc_q != 8'h00}; end
            OP_ROL:   begin acc_wr = 1'b1; acc_res = {acc_q[6:0], acc_q[7]}; end
            OP_ROR:   begin acc_wr = 1'b1; acc_res = {acc_q[0], acc_q[7:1]}; end
            OP_LDAR:  begin acc_wr = 1'b1; acc_res = rd_data; end
            OP_DEC:   begin acc_wr = 1'b1; acc_res = acc_q - 8'd1; end
            OP_CLR:   begin acc_wr = 1'b1; acc_res = 8'h00; end
            OP_NOT:   begin acc_wr = 1'b1; acc_res = ~acc_q; end
            OP_HLT:   state_d = ST_HALT;
            default: ;
          endcase
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;   // non-one-hot code recovers to FETCH
    endcase

    if (acc_wr) acc_d = locked ? ~acc_res : acc_res;

    if (st_wr) begin
      if (ir_q[4:0] == IO_ADDR) io_d = acc_q;
      for (int n = 0; n < MEM_BYTES; n++) begin
        if (ir_q[4:0] == 5'(n)) mem_d[n] = acc_q;
      end
    end
  end

  assign io_out = {scan_en ? key_so : (state_q == ST_HALT), io_q[7:1]};

endmodule

// File: tb/tb_lucaz97_tt_top.sv
module tb_lucaz97_tt_top;

  localparam logic [15:0] KEY_VAL = 16'hBFF9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_en_n = 1'b1;
  logic proc_en_n = 1'b1;
  logic scan_in = 1'b0;
  logic btn = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {2'b00, btn, scan_in, proc_en_n, scan_en_n, rst, clk};

  lucaz97_tt_top dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [159:0] exp_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (instruction-level ISA) ----------------
  logic [2:0]  m_st;
  logic [4:0]  m_pc;
  logic [7:0]  m_ir, m_acc, m_io;
  logic [15:0] m_key;
  logic [7:0]  m_mem [14];

  task automatic model_reset();
    m_st = 3'b001; m_pc = '0; m_ir = '0; m_acc = '0; m_io = '0; m_key = '0;
    for (int i = 0; i < 14; i++) m_mem[i] = '0;
  endtask

  function automatic logic [159:0] model_pack();
    logic [159:0] c;
    c = '0;
    c[2:0] = m_st; c[7:3] = m_pc; c[15:8] = m_ir; c[23:16] = m_acc;
    for (int i = 0; i < 14; i++) c[24 + 8*i +: 8] = m_mem[i];
    c[143:136] = m_io; c[159:144] = m_key;
    return c;
  endfunction

  task automatic model_unpack(input logic [159:0] c);
    m_st = c[2:0]; m_pc = c[7:3]; m_ir = c[15:8]; m_acc = c[23:16];
    for (int i = 0; i < 14; i++) m_mem[i] = c[24 + 8*i +: 8];
    m_io = c[143:136]; m_key = c[159:144];
  endtask

  function automatic logic [7:0] m_read(input logic [4:0] a);
    if (a < 5'd14) return m_mem[a];
    if (a == 5'd14) return {m_io[7:1], btn};
    return 8'h00;
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [7:0] v);
    if (a < 5'd14) m_mem[a] = v;
    else if (a == 5'd14) m_io = v;
  endtask

  task automatic model_clock();
    logic [7:0] op, val, res;
    logic [4:0] b;
    bit wr;
    op = m_ir; wr = 0; res = '0;
    case (m_st)
      3'b001: begin
        m_ir = m_read(m_pc);
        m_pc = m_pc + 5'd1;
        m_st = 3'b010;
      end
      3'b010: begin
        m_st = 3'b001;
        b = m_pc - 5'd1;
        if (op[7:5] != 3'b111) begin
          val = m_read(op[4:0]);
          wr = 1;
          case (op[7:5])
            3'd0: res = val;
            3'd1: begin wr = 0; m_write(op[4:0], m_acc); end
            3'd2: res = m_acc + val;
            3'd3: res = m_acc - val;
            3'd4: res = m_acc & val;
            3'd5: res = m_acc | val;
            default: res = m_acc ^ val;
          endcase
        end else if (!op[4]) begin
          wr = 1;
          res = m_acc + {{4{op[3]}}, op[3:0]};
        end else begin
          wr = 1;
          case (op[3:0])
            4'h0: begin wr = 0; m_pc = m_acc[4:0]; end
            4'h1: begin res = {3'b000, 5'(b + 5'd1)}; m_pc = m_acc[4:0]; end
            4'h2: begin wr = 0; if (m_acc == 0) m_pc = b + 5'd2; end
            4'h3: begin wr = 0; if (m_acc == 0) m_pc = b - 5'd2; end
            4'h4: begin wr = 0; if (m_acc != 0) m_pc = b + 5'd2; end
            4'h5: begin wr = 0; if (m_acc != 0) m_pc = b - 5'd2; end
            4'h6: res = m_acc << 1;
            4'h7: res = m_acc >> 1;
            4'h8: res = (m_acc != 0) ? 8'd1 : 8'd0;
            4'h9: res = {m_acc[6:0], m_acc[7]};
            4'hA: res = {m_acc[0], m_acc[7:1]};
            4'hB: res = m_read(m_acc[4:0]);
            4'hC: res = m_acc - 8'd1;
            4'hD: res = 8'h00;
            4'hE: res = ~m_acc;
            default: begin wr = 0; m_st = 3'b100; end
          endcase
        end
        if (wr) m_acc = (m_key != KEY_VAL) ? ~res : res;
      end
      3'b100: ;
      default: m_st = 3'b001;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Full 160-clock exchange, msb first in both directions.
  task automatic exchange(input logic [159:0] din, input bit with_proc, output logic [159:0] dout);
    @(negedge clk);
    scan_en_n = 1'b0;
    proc_en_n = with_proc ? 1'b0 : 1'b1;
    for (int k = 159; k >= 0; k--) begin
      #1 dout[k] = io_out[7];
      scan_in = din[k];
      @(negedge clk);
    end
    scan_en_n = 1'b1;
    proc_en_n = 1'b1;
  endtask

  task automatic xchg(input string tag, input logic [159:0] din, input bit with_proc,
                      output logic [159:0] dout);
    exp_q.push_back(model_pack());
    exchange(din, with_proc, dout);
    check(tag, dout, exp_q.pop_front());
    model_unpack(din);
  endtask

  task automatic run(input int n);
    @(negedge clk);
    proc_en_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      model_clock();
    end
    proc_en_n = 1'b1;
  endtask

  task automatic run_to_halt(input int max_clk);
    int used;
    used = 0;
    @(negedge clk);
    proc_en_n = 1'b0;
    while (used < max_clk) begin
      @(negedge clk);
      model_clock();
      used++;
      #1;
      if (io_out[7]) break;
    end
    proc_en_n = 1'b1;
  endtask

  function automatic logic [159:0] mk_chain(input logic [2:0] st, input logic [4:0] pc,
      input logic [7:0] ir, input logic [7:0] acc, input logic [7:0] io,
      input logic [15:0] key, input logic [111:0] mem);
    return {key, io, mem, acc, ir, pc, st};
  endfunction

  function automatic logic [159:0] rand_chain();
    logic [159:0] c;
    for (int i = 0; i < 5; i++) c[32*i +: 32] = $urandom();
    case ($urandom_range(0, 5))
      0, 1: c[2:0] = 3'b001;
      2:    c[2:0] = 3'b010;
      3:    c[2:0] = 3'b100;
      default: ;
    endcase
    if ($urandom_range(0, 2) != 0) c[159:144] = KEY_VAL;
    return c;
  endfunction

  // ---------------- stimulus ----------------
  logic [159:0] c1, c2, c3, c4, cr, dout;

  initial begin
    c1 = mk_chain(3'b001, 5'd1, 8'hE0, 8'h01, 8'hF0, KEY_VAL, {72'h0, 40'hE4E3E2E1E0});
    c4 = mk_chain(3'b001, 5'd1, 8'hE0, 8'h01, 8'hF0, 16'h0000, {72'h0, 40'hE4E3E2E1E0});
    c3 = mk_chain(3'b001, 5'd0, 8'h00, 8'h00, 8'h00, KEY_VAL,
                  112'h10_00_FF_F3_2C_E1_EF_F8_EF_F5_2D_FC_F2_0D);

    do_reset();
    #1 check("reset_io_out", io_out, 8'h00);

    // Case 1: load, LEDs, read back
    xchg("reset_chain", c1, 0, dout);
    check("reset_chain_const", dout, 160'h1);
    #1 check("case1_leds", io_out[6:0], 7'b1111000);
    check("case1_not_halted", io_out[7], 1'b0);
    xchg("case1_readback", c1, 0, dout);

    // Case 2: 8 clocks unlocked
    run(8);
    xchg("case2_unload", c4, 0, dout);
    check("case2_acc", dout[23:16], 8'h0B);
    check("case2_pc", dout[7:3], 5'd5);
    check("case2_ir", dout[15:8], 8'hE4);
    check("case2_state", dout[2:0], 3'b001);
    check("case2_mem", dout[63:24], 40'hE4E3E2E1E0);

    // Case 4: same program locked
    run(8);
    xchg("case4_unload", c3, 0, dout);
    check("case4_acc_locked", dout[23:16], 8'hFF);

    // Case 3: countdown program runs to HLT
    run_to_halt(256);
    check("case3_halted", io_out[7], 1'b1);
    xchg("case3_unload", c3, 0, dout);
    check("case3_mem13", dout[135:128], 8'h00);
    check("case3_mem12", dout[127:120], 8'h01);

    // Async reset while halted: io_out[7] drops with no clock edge
    run_to_halt(256);
    check("case3_halted_again", io_out[7], 1'b1);
    #2 rst = 1'b1;
    #1 check("halt_rst_async", io_out[7], 1'b0);
    rst = 1'b0;
    model_reset();
    xchg("halt_rst_chain", c3, 0, dout);
    check("halt_rst_chain_const", dout, 160'h1);

    // Case 5: async reset mid-run
    @(negedge clk);
    proc_en_n = 1'b0;
    repeat (20) begin
      @(negedge clk);
      model_clock();
    end
    #2 rst = 1'b1;
    #1 check("case5_io_out", io_out, 8'h00);
    rst = 1'b0;
    proc_en_n = 1'b1;
    model_reset();
    xchg("case5_chain", c1, 0, dout);
    check("case5_chain_const", dout, 160'h1);

    // Case 6: scan and proc together -> pure shift; then idle hold
    cr = rand_chain();
    cr[2:0] = 3'b001;
    cr[159:144] = KEY_VAL;
    xchg("case6_shift_only", cr, 1, dout);
    check("case6_const", dout, c1);
    repeat (10) @(negedge clk);
    xchg("idle_hold", c1, 0, dout);
    check("idle_hold_const", dout, cr);

    // Randomized programs against the model
    for (int it = 0; it < 40; it++) begin
      cr = rand_chain();
      xchg("rand_load", cr, 0, dout);
      btn = 1'($urandom_range(0, 1));
      run($urandom_range(2, 40));
    end
    xchg("rand_final", 160'h0, 0, dout);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
